fifo_burst_reader: RTL and testbench



---
 rtl/mini_tpu_pkg.sv | 13 +
 rtl/skid_buffer_2.sv | 45 ++++
 rtl/fifo_burst_reader.sv | 117 +++++++++++
 tb/tb_fifo_burst_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_tpu_pkg.sv
// Shared types and constants for the mini-TPU FIFO read path.
package mini_tpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } burst_state_t;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry circular buffer absorbing FIFO read latency in front of a valid/ready stream.
module skid_buffer_2
    import mini_tpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OCC_WIDTH-1:0]  occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    // Callers never push when full or pop when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                occ <= occ + OCC_WIDTH'(1);
            end else if (pop && !push) begin
                occ <= occ - OCC_WIDTH'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a fixed-length burst from a one-cycle-latency FIFO and streams it out with m_last.
module fifo_burst_reader
    import mini_tpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PEND_WIDTH = OCC_WIDTH + 1;

    burst_state_t          state;
    burst_state_t          state_nxt;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  len_nxt;
    logic [LEN_WIDTH-1:0]  issued_cnt;
    logic [LEN_WIDTH-1:0]  issued_nxt;
    logic [LEN_WIDTH-1:0]  sent_cnt;
    logic [LEN_WIDTH-1:0]  sent_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic                  inflight;
    logic [OCC_WIDTH-1:0]  occ;
    logic [PEND_WIDTH-1:0] pending;
    logic                  handshake;
    logic                  credit_ok;
    logic                  final_word;

    // Words buffered plus the one possibly returning from the FIFO must fit the skid.
    assign m_valid    = (occ != '0);
    assign handshake  = m_valid && m_ready;
    assign final_word = (sent_cnt == len - LEN_WIDTH'(1));
    assign m_last     = m_valid && final_word;
    assign pending    = PEND_WIDTH'(occ) + PEND_WIDTH'(inflight);
    assign credit_ok  = (pending < PEND_WIDTH'(SKID_DEPTH)) ||
                        ((pending == PEND_WIDTH'(SKID_DEPTH)) && handshake);
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued_cnt < len) && credit_ok;

    skid_buffer_2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (handshake),
        .occ       (occ),
        .head      (m_data)
    );

    always_comb begin
        state_nxt  = state;
        len_nxt    = len;
        issued_nxt = issued_cnt;
        sent_nxt   = sent_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt    = burst_len;
                    issued_nxt = '0;
                    sent_nxt   = '0;
                    state_nxt  = (burst_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (fifo_rd_en) begin
                    issued_nxt = issued_cnt + LEN_WIDTH'(1);
                end
                if (handshake) begin
                    sent_nxt = sent_cnt + LEN_WIDTH'(1);
                    if (final_word) begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == FIN);
    end

    // Clearing inflight on reset drops any FIFO return still on its way.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            issued_cnt <= '0;
            sent_cnt   <= '0;
            inflight   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            issued_cnt <= issued_nxt;
            sent_cnt   <= sent_nxt;
            inflight   <= fifo_rd_en;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, stream monitor and per-burst reference checks.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;
    localparam int BUDGET = 2000;

    logic          clk;
    logic          reset;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int nwords;
        int base;
        int rmode;
        int restart;
        int feed_at;
        int nfeed;
        int exp_done;
        int exp_first_pop;
        int exp_first_acc;
    } vec_t;

    int            total;
    int            bad;
    int            cyc;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] feed[$];
    logic [DW-1:0] pend_word;
    bit            pend;
    logic [DW:0]   rx[$];
    int            pop_n, acc_n, valid_n, done_n, done_cyc, first_pop, first_acc, busy_at1;
    int            v_empty, v_stable, v_outst, v_busy, v_last;
    bit            stalled_prev;
    logic [DW-1:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic clear_mon();
        rx.delete();
        pop_n = 0; acc_n = 0; valid_n = 0; done_n = 0;
        done_cyc = -1; first_pop = -1; first_acc = -1; busy_at1 = -1;
        v_empty = 0; v_stable = 0; v_outst = 0; v_busy = 0; v_last = 0;
        stalled_prev = 1'b0;
        cyc = 0;
    endtask

    // One clock: sample the settled cycle, model the FIFO pop, then advance.
    task automatic tick();
        fifo_empty = (fq.size() == 0);
        #1;
        if (fifo_rd_en === 1'b1) begin
            pop_n++;
            if (first_pop < 0) first_pop = cyc;
            if (fifo_empty) v_empty++;
            if (fq.size() > 0) begin
                pend_word = fq.pop_front();
                pend = 1'b1;
            end
        end
        if (m_valid === 1'b1) valid_n++;
        if (m_last === 1'b1 && m_valid !== 1'b1) v_last++;
        if (stalled_prev && (m_valid !== 1'b1 || m_data !== held)) v_stable++;
        stalled_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
        held = m_data;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            rx.push_back({m_last, m_data});
            acc_n++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (pop_n - acc_n > 2) v_outst++;
        if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
        if (done_n > 0 && busy === 1'b1) v_busy++;
        if (cyc == 1) busy_at1 = (busy === 1'b1) ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        fifo_data = pend ? pend_word : DW'($urandom);
        pend = 1'b0;
        cyc++;
    endtask

    // Expected stream: the first len words the FIFO will ever hold, in order.
    task automatic run_burst(input string name, input int len, input int rmode, input int restart,
                             input int feed_at, input bit frand, input int exp_done,
                             input int exp_first_pop, input int exp_first_acc);
        logic [DW-1:0] exp_w[$];
        logic [DW:0]   ent;
        bit            fin;
        bit            tail;
        foreach (fq[k])   if (exp_w.size() < len) exp_w.push_back(fq[k]);
        foreach (feed[k]) if (exp_w.size() < len) exp_w.push_back(feed[k]);
        clear_mon();
        fin = 1'b0;
        tail = 1'b0;
        while (!fin) begin
            start     = (cyc == 0) || (cyc == restart);
            burst_len = (cyc == 0) ? LW'(len) : LW'(2);
            m_ready   = ready_for(rmode, cyc);
            if (feed.size() > 0 && feed_at >= 0 && cyc >= feed_at) begin
                if (frand) begin
                    if ($urandom_range(0, 2) == 0) fq.push_back(feed.pop_front());
                end else begin
                    while (feed.size() > 0) fq.push_back(feed.pop_front());
                end
            end
            tick();
            if (tail) begin
                fin = 1'b1;
            end else if (done_n > 0) begin
                tail = 1'b1;
            end else if (cyc > BUDGET) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: no done after %0d cycles, accepted %0d of %0d", name, cyc, acc_n, len);
                fin = 1'b1;
            end
        end
        start = 1'b0;
        chk({name, "_count"}, 32'(rx.size()), 32'(len));
        for (int i = 0; i < rx.size() && i < len; i++) begin
            ent = rx[i];
            chk($sformatf("%s_data%0d", name, i), 32'(ent[DW-1:0]), 32'(exp_w[i]));
            chk($sformatf("%s_last%0d", name, i), 32'(ent[DW]), (i == len - 1) ? 32'd1 : 32'd0);
        end
        chk({name, "_pops"}, 32'(pop_n), 32'(len));
        chk({name, "_done_n"}, 32'(done_n), 32'd1);
        if (exp_done != -2)      chk({name, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
        if (exp_first_pop != -2) chk({name, "_first_pop"}, 32'(first_pop), 32'(exp_first_pop));
        if (exp_first_acc != -2) chk({name, "_first_acc"}, 32'(first_acc), 32'(exp_first_acc));
        chk({name, "_busy1"}, 32'(busy_at1), (len != 0) ? 32'd1 : 32'd0);
        chk({name, "_pop_empty"}, 32'(v_empty), 32'd0);
        chk({name, "_stable"}, 32'(v_stable), 32'd0);
        chk({name, "_outstanding"}, 32'(v_outst), 32'd0);
        chk({name, "_busy_after"}, 32'(v_busy), 32'd0);
        chk({name, "_last_nv"}, 32'(v_last), 32'd0);
        if (len == 0) chk({name, "_no_valid"}, 32'(valid_n), 32'd0);
        if (fin && done_n == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
    endtask

    vec_t vecs[6];
    int   rl, rnw, rex;

    initial begin
        total = 0; bad = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
        fifo_data = '0; fifo_empty = 1'b1; pend = 1'b0; stalled_prev = 1'b0; held = '0;
        clear_mon();
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_m_last", 32'(m_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // len nwords base rmode restart feed_at nfeed exp_done first_pop first_acc
        vecs[0] = '{5, 5, 'h10, 0, -1, -1, 0,  8,  1,  3};
        vecs[1] = '{8, 8, 'hA0, 1, -1, -1, 0, -2,  1,  3};
        vecs[2] = '{4, 2, 'h01, 0, -1,  6, 2, 10,  1,  3};
        vecs[3] = '{0, 2, 'h55, 0, -1, -1, 0,  1, -1, -1};
        vecs[4] = '{3, 5, 'h60, 0,  2, -1, 0,  6,  1,  3};
        vecs[5] = '{1, 1, 'h77, 0, -1, -1, 0,  4,  1,  3};
        for (int i = 0; i < 6; i++) begin
            fq.delete();
            feed.delete();
            for (int k = 0; k < vecs[i].nwords; k++) fq.push_back(DW'(vecs[i].base + k));
            for (int k = 0; k < vecs[i].nfeed; k++)
                feed.push_back(DW'(vecs[i].base + vecs[i].nwords + k));
            run_burst($sformatf("vec%0d", i), vecs[i].len, vecs[i].rmode, vecs[i].restart,
                      vecs[i].feed_at, 1'b0, vecs[i].exp_done, vecs[i].exp_first_pop,
                      vecs[i].exp_first_acc);
        end

        // Reset in the middle of a 6-word burst, then a clean 2-word burst.
        fq.delete();
        feed.delete();
        for (int k = 0; k < 8; k++) fq.push_back(DW'(8'h30 + k));
        clear_mon();
        start = 1'b1; burst_len = LW'(6); m_ready = 1'b1;
        tick();
        start = 1'b0;
        while (acc_n < 2 && cyc < 50) tick();
        chk("rst_mid_accepted", 32'(acc_n), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_m_data", 32'(m_data), 32'd0);
        chk("rst_mid_m_last", 32'(m_last), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        valid_n = 0;
        stalled_prev = 1'b0;
        tick(); tick(); tick();
        chk("rst_mid_discard", 32'(valid_n), 32'd0);
        chk("rst_mid_no_done", 32'(done_n), 32'd0);
        run_burst("after_rst", 2, 0, -1, -1, 1'b0, 5, 1, 3);

        // Random bursts with a trickling FIFO and random backpressure.
        fq.delete();
        feed.delete();
        for (int r = 0; r < 10; r++) begin
            rl  = $urandom_range(1, 24);
            rnw = $urandom_range(0, rl);
            rex = $urandom_range(0, 2);
            for (int k = 0; k < rnw; k++) fq.push_back(DW'($urandom));
            for (int k = 0; k < rl - rnw + rex; k++) feed.push_back(DW'($urandom));
            run_burst($sformatf("rnd%0d", r), rl, 2, -1, 1, 1'b1, -2, -2, -2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
